// File: rtl/dmem_mmio_bridge.sv
// dmem_mmio_bridge
//   Routes rv32i_core data accesses either to ram_wrap or to a small
//   memory-mapped register block (display latch, LEDs, switches, cycle
//   counter, control). Read data always returns one cycle after dmem_r,
//   for both RAM and IO targets.
//
// Ports
//   m_clock   system clock, rising edge
//   p_reset   asynchronous active-high reset
//   dmem_r    core read strobe (one cycle per access)
//   dmem_w    core write strobe (one cycle per access)
//   daddr     core word address
//   wdata     core write data
//   rdata     read data, valid the cycle after dmem_r
//   ram_addr  address to ram_wrap (always daddr)
//   ram_wdata write data to ram_wrap (always wdata)
//   ram_rden  byte read enables to ram_wrap
//   ram_wren  byte write enables to ram_wrap
//   ram_rdata read data from ram_wrap, one cycle after ram_rden
//   disp_data display latch, drives seg7_ctrl
//   led       LED register
//   sw        asynchronous switch inputs
//   bus_err   one-cycle pulse following an illegal access
module dmem_mmio_bridge #(
  parameter logic [31:0] IO_BASE = 32'h8000_0000,
  parameter int          RAM_AW  = 16,
  parameter int          LED_W   = 8,
  parameter int          SW_W    = 8
) (
  input  logic             m_clock,
  input  logic             p_reset,
  input  logic             dmem_r,
  input  logic             dmem_w,
  input  logic [31:0]      daddr,
  input  logic [31:0]      wdata,
  output logic [31:0]      rdata,
  output logic [31:0]      ram_addr,
  output logic [31:0]      ram_wdata,
  output logic [3:0]       ram_rden,
  output logic [3:0]       ram_wren,
  input  logic [31:0]      ram_rdata,
  output logic [31:0]      disp_data,
  output logic [LED_W-1:0] led,
  input  logic [SW_W-1:0]  sw,
  output logic             bus_err
);

  typedef enum logic [1:0] {
    SEL_NONE = 2'd0,
    SEL_RAM  = 2'd1,
    SEL_IO   = 2'd2
  } sel_t;

  localparam logic [5:0] W_DISP  = 6'd0;
  localparam logic [5:0] W_LED   = 6'd1;
  localparam logic [5:0] W_SW    = 6'd2;
  localparam logic [5:0] W_CYCLE = 6'd3;
  localparam logic [5:0] W_CTRL  = 6'd4;

  logic [31:0]     disp_q;
  logic [LED_W-1:0] led_q;
  logic [SW_W-1:0] sw_s1, sw_s2;
  logic [31:0]     cycle_q;
  logic            en_q;

  logic            is_ram, is_io, io_ok;
  logic [5:0]      word;
  logic            rd_go, wr_io, clr, err_p0;
  sel_t            sel_p0, sel_p1;
  logic [31:0]     io_rd_p0, io_rd_p1;
  logic            bus_err_p1;

  // Stage p0: combinational decode of the current access
  assign is_ram = ((daddr >> RAM_AW) == 32'd0);
  assign is_io  = !is_ram && (daddr[31:8] == IO_BASE[31:8]);
  assign word   = daddr[7:2];
  assign io_ok  = is_io && (word <= W_CTRL);

  // A simultaneous read+write keeps the write and drops the read.
  assign rd_go  = dmem_r && !dmem_w;
  assign wr_io  = dmem_w && io_ok;
  assign clr    = wr_io && (word == W_CTRL) && wdata[1];
  assign err_p0 = ((dmem_r || dmem_w) && !is_ram && !io_ok) || (dmem_r && dmem_w);

  assign ram_addr  = daddr;
  assign ram_wdata = wdata;
  assign ram_rden  = (rd_go && is_ram) ? 4'b1111 : 4'b0000;
  assign ram_wren  = (dmem_w && is_ram) ? 4'b1111 : 4'b0000;

  always_comb begin
    sel_p0 = SEL_NONE;
    if (rd_go && is_ram)     sel_p0 = SEL_RAM;
    else if (rd_go && io_ok) sel_p0 = SEL_IO;
  end

  always_comb begin
    io_rd_p0 = 32'd0;
    case (word)
      W_DISP:  io_rd_p0 = disp_q;
      W_LED:   io_rd_p0 = {{(32-LED_W){1'b0}}, led_q};
      W_SW:    io_rd_p0 = {{(32-SW_W){1'b0}}, sw_s2};
      W_CYCLE: io_rd_p0 = cycle_q;
      W_CTRL:  io_rd_p0 = {31'd0, en_q};
      default: io_rd_p0 = 32'd0;
    endcase
  end

  // Register block state
  always_ff @(posedge m_clock or posedge p_reset) begin
    if (p_reset) begin
      disp_q  <= 32'd0;
      led_q   <= '0;
      en_q    <= 1'b1;
      cycle_q <= 32'd0;
      sw_s1   <= '0;
      sw_s2   <= '0;
    end else begin
      sw_s1 <= sw;
      sw_s2 <= sw_s1;
      if (wr_io && word == W_DISP) disp_q <= wdata;
      if (wr_io && word == W_LED)  led_q  <= wdata[LED_W-1:0];
      if (wr_io && word == W_CTRL) en_q   <= wdata[0];
      // Clear wins over increment; increment uses the enable in force
      // before this edge.
      if (clr)       cycle_q <= 32'd0;
      else if (en_q) cycle_q <= cycle_q + 32'd1;
    end
  end

  // Stage p1: registered read target and error pulse
  always_ff @(posedge m_clock or posedge p_reset) begin
    if (p_reset) begin
      sel_p1     <= SEL_NONE;
      bus_err_p1 <= 1'b0;
    end else begin
      sel_p1     <= sel_p0;
      bus_err_p1 <= err_p0;
    end
  end

  always_ff @(posedge m_clock) begin
    io_rd_p1 <= io_rd_p0;
  end

  // The async reset clears sel_p1, which forces rdata to 0 at once.
  always_comb begin
    rdata = 32'd0;
    case (sel_p1)
      SEL_RAM: rdata = ram_rdata;
      SEL_IO:  rdata = io_rd_p1;
      default: rdata = 32'd0;
    endcase
  end

  assign disp_data = disp_q;
  assign led       = led_q;
  assign bus_err   = bus_err_p1;

endmodule

// File: tb/tb_dmem_mmio_bridge.sv
module tb_dmem_mmio_bridge;

  localparam logic [31:0] IOB = 32'h8000_0000;

  logic        m_clock = 1'b0;
  logic        p_reset;
  logic        dmem_r, dmem_w;
  logic [31:0] daddr, wdata, rdata;
  logic [31:0] ram_addr, ram_wdata, ram_rdata;
  logic [3:0]  ram_rden, ram_wren;
  logic [31:0] disp_data;
  logic [7:0]  led, sw;
  logic        bus_err;

  int total = 0;
  int bad   = 0;

  logic [31:0] mem [0:255];

  dmem_mmio_bridge dut (
    .m_clock(m_clock), .p_reset(p_reset), .dmem_r(dmem_r), .dmem_w(dmem_w),
    .daddr(daddr), .wdata(wdata), .rdata(rdata), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_rden(ram_rden), .ram_wren(ram_wren),
    .ram_rdata(ram_rdata), .disp_data(disp_data), .led(led), .sw(sw),
    .bus_err(bus_err)
  );

  always #5 m_clock = ~m_clock;

  // Behavioural ram_wrap: one-cycle registered read.
  always @(posedge m_clock) begin
    if (ram_wren == 4'b1111) mem[ram_addr[9:2]] <= ram_wdata;
    if (ram_rden == 4'b1111) ram_rdata <= mem[ram_addr[9:2]];
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  // All tasks start and end at a falling edge.
  task automatic do_write(input logic [31:0] a, input logic [31:0] d);
    dmem_w = 1'b1; daddr = a; wdata = d;
    @(negedge m_clock);
    dmem_w = 1'b0;
  endtask

  task automatic do_read(input string tag, input logic [31:0] a, input logic [31:0] exp);
    dmem_r = 1'b1; daddr = a;
    @(negedge m_clock);
    dmem_r = 1'b0;
    chk(tag, rdata, exp);
  endtask

  initial begin
    p_reset = 1'b1; dmem_r = 1'b0; dmem_w = 1'b0;
    daddr = 32'd0; wdata = 32'd0; sw = 8'h00; ram_rdata = 32'd0;
    for (int i = 0; i < 256; i++) mem[i] = 32'd0;
    repeat (3) @(negedge m_clock);
    p_reset = 1'b0;

    // Reset state and free-running counter after five edges
    repeat (5) @(negedge m_clock);
    chk("rst_disp", disp_data, 32'd0);
    chk("rst_led", {24'd0, led}, 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_err", {31'd0, bus_err}, 32'd0);
    do_read("rst_cycle", IOB + 32'h0C, 32'd5);

    // Display latch and LED register
    do_write(IOB + 32'h00, 32'h1234_5678);
    chk("disp_wr", disp_data, 32'h1234_5678);
    do_write(IOB + 32'h04, 32'h0000_00A5);
    chk("led_wr", {24'd0, led}, 32'h0000_00A5);
    do_read("disp_rd", IOB + 32'h00, 32'h1234_5678);
    do_read("led_rd", IOB + 32'h04, 32'h0000_00A5);

    // RAM write, read, then back-to-back RAM and IO reads
    dmem_w = 1'b1; daddr = 32'h40; wdata = 32'hDEAD_BEEF;
    #1 chk("ram_wren", {28'd0, ram_wren}, 32'hF);
    @(negedge m_clock);
    dmem_w = 1'b0;
    dmem_r = 1'b1; daddr = 32'h40;
    #1 chk("ram_rden", {28'd0, ram_rden}, 32'hF);
    @(negedge m_clock);
    chk("ram_rd", rdata, 32'hDEAD_BEEF);
    daddr = IOB;
    #1 chk("io_no_rden", {28'd0, ram_rden}, 32'h0);
    @(negedge m_clock);
    dmem_r = 1'b0;
    chk("b2b_io_rd", rdata, 32'h1234_5678);
    @(negedge m_clock);
    chk("idle_rdata", rdata, 32'd0);

    // Switch synchroniser latency
    sw = 8'h3C;
    @(negedge m_clock);
    do_read("sw_old", IOB + 32'h08, 32'd0);
    @(negedge m_clock);
    do_read("sw_new", IOB + 32'h08, 32'h0000_003C);

    // Cycle counter clear, enable and stop
    do_write(IOB + 32'h10, 32'd3);
    do_read("cyc_clr", IOB + 32'h0C, 32'd0);
    do_write(IOB + 32'h10, 32'd0);
    do_read("cyc_stop1", IOB + 32'h0C, 32'd2);
    repeat (10) @(negedge m_clock);
    do_read("cyc_stop2", IOB + 32'h0C, 32'd2);
    do_read("ctrl_rd", IOB + 32'h10, 32'd0);

    // Unmapped read
    do_read("unmap_rd", 32'h4000_0000, 32'd0);
    chk("unmap_err", {31'd0, bus_err}, 32'd1);
    @(negedge m_clock);
    chk("unmap_err_end", {31'd0, bus_err}, 32'd0);

    // Undefined IO offset write is dropped and flagged
    do_write(IOB + 32'h14, 32'hFFFF_FFFF);
    chk("undef_err", {31'd0, bus_err}, 32'd1);
    chk("undef_disp", disp_data, 32'h1234_5678);

    // Write to a read-only offset is silently ignored
    do_write(IOB + 32'h08, 32'hFFFF_FFFF);
    chk("ro_no_err", {31'd0, bus_err}, 32'd0);

    // Read and write together: write wins, read dropped, error flagged
    dmem_r = 1'b1; dmem_w = 1'b1; daddr = IOB; wdata = 32'h77;
    @(negedge m_clock);
    dmem_r = 1'b0; dmem_w = 1'b0;
    chk("rw_disp", disp_data, 32'h77);
    chk("rw_rdata", rdata, 32'd0);
    chk("rw_err", {31'd0, bus_err}, 32'd1);
    @(negedge m_clock);
    chk("rw_err_end", {31'd0, bus_err}, 32'd0);

    // Reset in the middle of a pending read result
    dmem_r = 1'b1; daddr = 32'h40;
    @(negedge m_clock);
    dmem_r = 1'b0;
    chk("pre_rst_rd", rdata, 32'hDEAD_BEEF);
    #1 p_reset = 1'b1;
    #1 chk("rst_async_rdata", rdata, 32'd0);
    chk("rst_async_disp", disp_data, 32'd0);
    @(negedge m_clock);
    p_reset = 1'b0;
    @(negedge m_clock);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got=running exp=finished");
    $fatal(1);
  end

endmodule
